// File: rtl/dm_banked_ctrl.sv
// Banked MEM-stage data memory: byte/half/word loads and stores, configurable latency,
// and fault reporting for bad accesses. Define DM_TRACE_EN to print store and fault trace lines.
module dm_banked_ctrl #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic [3:0]  counter;
  logic        lat_we;
  logic [2:0]  lat_op;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] lat_pc;
  logic [31:0] mem [WORDS];

  logic        chk_fault;
  logic [1:0]  chk_code;
  logic        accept;
  logic        commit;

  logic        acc_we;
  logic [2:0]  acc_op;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [31:0] acc_pc;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0] cur;
  logic [15:0] cur_half;
  logic [7:0]  cur_byte;
  logic [31:0] load_val;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data;
  logic [31:0] merged;
  logic        unused_trace;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Request checks in priority order: invalid op, out of range, misaligned.
  always_comb begin
    chk_code = 2'd0;
    if (op > 3'd4)
      chk_code = 2'd3;
    else if ((addr >> (DEPTH_LOG2 + 2)) != 32'd0)
      chk_code = 2'd2;
    else if ((op == 3'd0 && addr[1:0] != 2'b00) ||
             ((op == 3'd1 || op == 3'd2) && addr[0]))
      chk_code = 2'd1;
  end

  assign chk_fault = (chk_code != 2'd0);
  assign accept    = (state == IDLE) && req;
  assign commit    = (accept && !chk_fault && LATENCY == 1) ||
                     (state == WAIT && counter == 4'd0);

  // With a single-edge latency the access commits on the accept edge, straight from the inputs.
  assign acc_we    = (state == IDLE) ? we    : lat_we;
  assign acc_op    = (state == IDLE) ? op    : lat_op;
  assign acc_addr  = (state == IDLE) ? addr  : lat_addr;
  assign acc_wdata = (state == IDLE) ? wdata : lat_wdata;
  assign acc_pc    = (state == IDLE) ? pc    : lat_pc;

  assign idx      = acc_addr[DEPTH_LOG2+1:2];
  assign cur      = mem[idx];
  assign cur_half = acc_addr[1] ? cur[31:16] : cur[15:0];
  assign cur_byte = 8'(cur >> {acc_addr[1:0], 3'b000});

  always_comb begin
    load_val = cur;
    case (acc_op)
      3'd1:    load_val = {{16{cur_half[15]}}, cur_half};
      3'd2:    load_val = {16'd0, cur_half};
      3'd3:    load_val = {{24{cur_byte[7]}}, cur_byte};
      3'd4:    load_val = {24'd0, cur_byte};
      default: load_val = cur;
    endcase
  end

  always_comb begin
    lane_mask = 4'b1111;
    lane_data = acc_wdata;
    case (acc_op)
      3'd1, 3'd2: begin
        lane_mask = acc_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{acc_wdata[15:0]}};
      end
      3'd3, 3'd4: begin
        lane_mask = 4'b0001 << acc_addr[1:0];
        lane_data = {4{acc_wdata[7:0]}};
      end
      default: begin
        lane_mask = 4'b1111;
        lane_data = acc_wdata;
      end
    endcase
    merged = cur;
    for (int i = 0; i < 4; i++)
      if (lane_mask[i]) merged[8*i +: 8] = lane_data[8*i +: 8];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      counter    <= 4'd0;
      fault      <= 1'b0;
      fault_code <= 2'd0;
      lat_we     <= 1'b0;
      lat_op     <= 3'd0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_pc     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            lat_we    <= we;
            lat_op    <= op;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            lat_pc    <= pc;
            if (chk_fault) begin
              fault      <= 1'b1;
              fault_code <= chk_code;
              state      <= DONE;
            end else if (LATENCY == 1) begin
              state <= DONE;
            end else begin
              counter <= CNT_INIT;
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (counter == 4'd0)
            state <= DONE;
          else
            counter <= counter - 4'd1;
        end
        DONE: begin
          fault      <= 1'b0;
          fault_code <= 2'd0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory and load result; reset clears every word so an abandoned store leaves no trace.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WORDS; i++)
        mem[i] <= 32'd0;
      rdata <= 32'd0;
    end else if (commit) begin
      if (acc_we)
        mem[idx] <= merged;
      else
        rdata <= load_val;
    end
  end

`ifdef DM_TRACE_EN
  logic [31:0] trace_data;

  always_comb begin
    case (acc_op)
      3'd1, 3'd2: trace_data = {16'd0, acc_wdata[15:0]};
      3'd3, 3'd4: trace_data = {24'd0, acc_wdata[7:0]};
      default:    trace_data = acc_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (commit && acc_we)
        $display("%d@%h: *%h <= %h", $time, acc_pc, acc_addr, trace_data);
      if (accept && chk_fault)
        $display("%d@%h: DM fault %d @ %h", $time, pc, chk_code, addr);
    end
  end
`endif

  assign unused_trace = ^acc_pc;

endmodule

// File: tb/tb_dm_banked_ctrl.sv
// Randomized bench for dm_banked_ctrl: one instance at LATENCY=1 and one at LATENCY=4,
// checked against a byte-array reference model.
module tb_dm_banked_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req1, req4;
  logic        we;
  logic [2:0]  op;
  logic [31:0] addr, wdata, pc;

  logic        busy1, done1, fault1;
  logic [31:0] rdata1;
  logic [1:0]  code1;
  logic        busy4, done4, fault4;
  logic [31:0] rdata4;
  logic [1:0]  code4;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mdl [2][4096];
  logic [31:0] mrd [2];

  always #5 clk = ~clk;

  dm_banked_ctrl #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(we), .op(op), .addr(addr),
    .wdata(wdata), .pc(pc), .busy(busy1), .done(done1), .rdata(rdata1),
    .fault(fault1), .fault_code(code1));

  dm_banked_ctrl #(.DEPTH_LOG2(10), .LATENCY(4)) dut4 (
    .clk(clk), .reset(reset), .req(req4), .we(we), .op(op), .addr(addr),
    .wdata(wdata), .pc(pc), .busy(busy4), .done(done4), .rdata(rdata4),
    .fault(fault4), .fault_code(code4));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_code(input logic [2:0] o, input logic [31:0] a);
    if (o > 4) return 2'd3;
    if (a >= 32'd4096) return 2'd2;
    if (o == 0 && a % 4 != 0) return 2'd1;
    if ((o == 1 || o == 2) && a % 2 != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic int size_of(input logic [2:0] o);
    if (o == 0) return 4;
    if (o <= 2) return 2;
    return 1;
  endfunction

  task automatic model_store(input int s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < size_of(o); k++)
      mdl[s][int'(a) + k] = 8'(d >> (8 * k));
  endtask

  function automatic logic [31:0] model_load(input int s, input logic [2:0] o, input logic [31:0] a);
    logic [31:0] v = 0;
    int n = size_of(o);
    for (int k = 0; k < n; k++)
      v = v + (32'(mdl[s][int'(a) + k]) << (8 * k));
    if (o == 1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
    if (o == 3 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
    return v;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4096; i++) mdl[s][i] = 8'd0;
      mrd[s] = 32'd0;
    end
  endtask

  task automatic sample(input int s, output logic b, output logic dn, output logic f,
                        output logic [1:0] c, output logic [31:0] r);
    if (s == 1) begin b = busy4; dn = done4; f = fault4; c = code4; r = rdata4; end
    else        begin b = busy1; dn = done1; f = fault1; c = code1; r = rdata1; end
  endtask

  // One access; req stays high through the whole busy window while the other inputs are scrambled.
  task automatic applyStimulus(input int s, input logic w, input logic [2:0] o,
                               input logic [31:0] a, input logic [31:0] d);
    logic [1:0]  ec;
    int          n, exp_lat;
    logic        b, dn, f;
    logic [1:0]  c;
    logic [31:0] r;
    @(negedge clk);
    we = w; op = o; addr = a; wdata = d; pc = $urandom;
    if (s == 1) req4 = 1'b1; else req1 = 1'b1;
    ec = exp_code(o, a);
    if (ec == 0) begin
      if (w) model_store(s, o, a, d);
      else   mrd[s] = model_load(s, o, a);
    end
    exp_lat = (ec != 0) ? 1 : (s == 1 ? 4 : 1);
    n = 0;
    dn = 1'b0;
    while (!dn && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      sample(s, b, dn, f, c, r);
      checkOutput("busy_inflight", 32'(b), 32'd1);
      we = 1'($urandom); op = 3'($urandom); addr = $urandom; wdata = $urandom;
    end
    checkOutput("latency", 32'(n), 32'(exp_lat));
    checkOutput("fault", 32'(f), 32'(ec != 0));
    checkOutput("fault_code", 32'(c), 32'(ec));
    checkOutput("rdata", r, mrd[s]);
    @(posedge clk);
    #1;
    sample(s, b, dn, f, c, r);
    checkOutput("busy_after", 32'(b), 32'd0);
    checkOutput("done_after", 32'(dn), 32'd0);
    checkOutput("fault_clear", 32'({f, c}), 32'd0);
    req1 = 1'b0;
    req4 = 1'b0;
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a;
    int          s, r;
    reset = 1'b0; req1 = 0; req4 = 0; we = 0; op = 0; addr = 0; wdata = 0; pc = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'({busy1, busy4}), 32'd0);
    checkOutput("rst_done", 32'({done1, done4}), 32'd0);
    checkOutput("rst_rdata", rdata1 | rdata4, 32'd0);
    checkOutput("rst_fault", 32'({fault1, code1, fault4, code4}), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(0, 1, 3'd0, 32'h10, 32'h1234_5678);
    applyStimulus(0, 0, 3'd0, 32'h10, 32'h0);
    checkOutput("tp_word", rdata1, 32'h1234_5678);
    applyStimulus(0, 1, 3'd3, 32'h11, 32'h0000_00AB);
    applyStimulus(0, 0, 3'd3, 32'h11, 32'h0);
    checkOutput("tp_sbyte", rdata1, 32'hFFFF_FFAB);
    applyStimulus(0, 0, 3'd2, 32'h10, 32'h0);
    checkOutput("tp_uhalf", rdata1, 32'h0000_AB78);
    applyStimulus(0, 0, 3'd0, 32'h10, 32'h0);
    checkOutput("tp_merged", rdata1, 32'h1234_AB78);
    applyStimulus(0, 0, 3'd0, 32'h2, 32'h0);
    checkOutput("tp_misalign_hold", rdata1, 32'h1234_AB78);
    applyStimulus(0, 0, 3'd0, 32'h1000, 32'h0);
    applyStimulus(0, 0, 3'd6, 32'h10, 32'h0);
    applyStimulus(0, 1, 3'd6, 32'h10, 32'hFFFF_FFFF);
    applyStimulus(0, 0, 3'd0, 32'h10, 32'h0);
    checkOutput("tp_badop_store", rdata1, 32'h1234_AB78);

    applyStimulus(1, 1, 3'd0, 32'h24, 32'hDEAD_BEEF);
    applyStimulus(1, 1, 3'd1, 32'h26, 32'h0000_8001);
    applyStimulus(1, 0, 3'd1, 32'h26, 32'h0);
    checkOutput("tp4_shalf", rdata4, 32'hFFFF_8001);
    applyStimulus(1, 0, 3'd0, 32'h24, 32'h0);
    checkOutput("tp4_word", rdata4, 32'h8001_BEEF);

    // Reset in the middle of a slow store.
    @(negedge clk);
    we = 1; op = 3'd0; addr = 32'h20; wdata = 32'hCAFE_F00D; req4 = 1'b1;
    @(posedge clk);
    #1;
    req4 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("rst_mid_busy", 32'(busy4), 32'd0);
    checkOutput("rst_mid_done", 32'(done4), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1, 0, 3'd0, 32'h20, 32'h0);
    checkOutput("rst_abandon", rdata4, 32'h0);
    applyStimulus(1, 0, 3'd0, 32'h24, 32'h0);
    checkOutput("rst_mem_clear", rdata4, 32'h0);

    for (int i = 0; i < 300; i++) begin
      s = $urandom_range(0, 1);
      r = $urandom_range(0, 19);
      o = 3'($urandom_range(0, 4));
      a = 32'($urandom_range(0, 127));
      if (r == 0) a = $urandom;
      if (r == 1) a = 32'h1000 + 32'($urandom_range(0, 255));
      if (r == 2) o = 3'($urandom_range(5, 7));
      if (r > 4) begin
        if (o == 0) a = a & ~32'd3;
        if (o == 1 || o == 2) a = a & ~32'd1;
      end
      applyStimulus(s, 1'($urandom), o, a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
